// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store buffer: FSM states, the buffered
// store entry and the default buffer depth.
package dmem_pkg;

  localparam int SBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } store_entry_t;

endpackage

// File: rtl/sbuf_fifo.sv
// Program-order store FIFO with a per-entry word-address match vector so the
// owner can detect loads that alias a buffered store.
module sbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH  = SBUF_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  store_entry_t       push_entry,
  input  logic               pop,
  input  logic [ADDR_W-1:2]  match_word,
  output store_entry_t       head,
  output logic               full,
  output logic               empty,
  output logic [DEPTH-1:0]   match_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] slot_off [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full buffer is legal only when the head retires on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage carries no reset; occupancy is tracked by count alone,
  // so stale slots are never observed and the array maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  // NOTE: every always_comb output is given a default before any conditional
  // logic so no path can infer a latch.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i]  = PTR_W'(i) - rd_ptr;
      match_vec[i] = ({1'b0, slot_off[i]} < count) &&
                     (mem[i].addr[ADDR_W-1:2] == match_word);
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the pipeline and the data cache; loads take priority
// over draining stores. Define STORE_BUF_BYPASS_EN to let non-aliasing loads
// overtake buffered stores.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH  = SBUF_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_write_data,
  output logic        cache_memwrite,
  output logic        cache_memread,
  output logic [3:0]  cache_sign_mask,
  input  logic [31:0] cache_read_data,
  input  logic        cache_stall
);

`ifdef STORE_BUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  state_t           state;
  logic             is_load;
  logic             load_done;
  store_entry_t     head;
  store_entry_t     push_entry;
  logic             full;
  logic             empty;
  logic [DEPTH-1:0] match_vec;
  logic             pop_now;
  logic             push;
  logic             load_ok;
  logic             load_go;

  assign push_entry = '{addr: cpu_addr, data: cpu_write_data, sign_mask: cpu_sign_mask};
  assign pop_now    = (state == WAIT_LO) && !cache_stall && !is_load;
  assign push       = cpu_memwrite && (!full || pop_now);
  // An empty buffer never matches, so the non-bypass case reduces to "empty".
  assign load_ok    = ~|match_vec && (BYPASS || empty);
  // load_done marks the cycle after capture, where the served load is still presented.
  assign load_go    = cpu_memread && !load_done && load_ok;
  assign cpu_stall  = (cpu_memread && !load_done) || (cpu_memwrite && full && !pop_now);

  sbuf_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop_now),
    .match_word (cpu_addr[ADDR_W-1:2]),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .match_vec  (match_vec)
  );

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      is_load          <= 1'b0;
      load_done        <= 1'b0;
      cpu_read_data    <= '0;
      cache_addr       <= '0;
      cache_write_data <= '0;
      cache_sign_mask  <= '0;
      cache_memwrite   <= 1'b0;
      cache_memread    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_go) begin
            state            <= ISSUE;
            is_load          <= 1'b1;
            cache_memread    <= 1'b1;
            cache_addr       <= cpu_addr;
            cache_write_data <= '0;
            cache_sign_mask  <= cpu_sign_mask;
          end else if (!empty) begin
            state            <= ISSUE;
            is_load          <= 1'b0;
            cache_memwrite   <= 1'b1;
            cache_addr       <= head.addr;
            cache_write_data <= head.data;
            cache_sign_mask  <= head.sign_mask;
          end
        end
        ISSUE: begin
          cache_memread  <= 1'b0;
          cache_memwrite <= 1'b0;
          state          <= WAIT_HI;
        end
        WAIT_HI: begin
          if (cache_stall) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!cache_stall) begin
            state <= IDLE;
            if (is_load) begin
              cpu_read_data <= cache_read_data;
              load_done     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
